id_ex_stage_reg: RTL and testbench

- Pipeline register between the Decode (ID) and Execute (EX) stages of the 5-stage MIPS32 pipeline.
- Latches the decoded control bundle, operands and register specifiers once per cycle.
- Its ALUOp and funct outputs drive ALUCtrl and JR_Ctrl in EX directly.
- Supports a hold (load-use stall), a flush (bubble insertion on branch/jr redirect), a valid bit, and a saturating bubble counter for performance debug.

---
 rtl/id_ex_stage_reg.sv | 175 +++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//
// Pipeline register between the Decode (ID) and Execute (EX) stages of the
// 5-stage MIPS32 pipeline. Latches the decoded control bundle, operands and
// register specifiers once per cycle, supports a load-use hold, a bubble
// flush on branch/jr redirect, and a saturating bubble counter for debug.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   stall                   hold current contents (load-use hazard)
//   flush                   replace next contents with a bubble
//   id_valid                ID holds a real instruction
//   id_ALUOp, id_funct      ALU decode inputs (to ALUCtrl / JR_Ctrl in EX)
//   id_ctrl                 {RegWrite, MemtoReg, MemRead, MemWrite,
//                            Branch, RegDst, ALUSrc}
//   id_pc4, id_rdata1,
//   id_rdata2, id_imm       DATA_W-wide data fields
//   id_rs, id_rt, id_rd     register specifiers
//   ex_*                    registered copies of the id_* fields
//   ex_valid                EX holds a real instruction
//   bubble_cnt              flush-inserted bubbles since reset (saturating)
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [1:0]        id_ALUOp,
    input  logic [5:0]        id_funct,
    input  logic [6:0]        id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    output logic              ex_valid,
    output logic [1:0]        ex_ALUOp,
    output logic [5:0]        ex_funct,
    output logic [6:0]        ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    logic              valid_q,  valid_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic [5:0]        funct_q,  funct_d;
    logic [6:0]        ctrl_q,   ctrl_d;
    logic [DATA_W-1:0] pc4_q,    pc4_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [DATA_W-1:0] imm_q,    imm_d;
    logic [REG_AW-1:0] rs_q,     rs_d;
    logic [REG_AW-1:0] rt_q,     rt_d;
    logic [REG_AW-1:0] rd_q,     rd_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    always_comb begin
        // Default: hold everything (covers stall).
        valid_d  = valid_q;
        alu_op_d = alu_op_q;
        funct_d  = funct_q;
        ctrl_d   = ctrl_q;
        pc4_d    = pc4_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;

        if (flush || !stall) begin
            // Data and specifiers always follow ID when not held; they are
            // don't-care in EX whenever the control side is a bubble.
            pc4_d    = id_pc4;
            rdata1_d = id_rdata1;
            rdata2_d = id_rdata2;
            imm_d    = id_imm;
            rs_d     = id_rs;
            rt_d     = id_rt;
            rd_d     = id_rd;
        end

        if (flush) begin
            // Zeroing funct as well as ALUOp keeps a flushed jr from
            // raising JR_Ctrl in EX.
            valid_d  = 1'b0;
            alu_op_d = 2'b00;
            funct_d  = 6'b000000;
            ctrl_d   = 7'b0000000;
            cnt_d    = sat_inc(cnt_q);
        end else if (!stall) begin
            valid_d = id_valid;
            if (id_valid) begin
                alu_op_d = id_ALUOp;
                funct_d  = id_funct;
                ctrl_d   = id_ctrl;
            end else begin
                // Natural bubble from ID: squash control, not counted.
                alu_op_d = 2'b00;
                funct_d  = 6'b000000;
                ctrl_d   = 7'b0000000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            alu_op_q <= '0;
            funct_q  <= '0;
            ctrl_q   <= '0;
            pc4_q    <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            alu_op_q <= alu_op_d;
            funct_q  <= funct_d;
            ctrl_q   <= ctrl_d;
            pc4_q    <= pc4_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_ALUOp   = alu_op_q;
    assign ex_funct   = funct_q;
    assign ex_ctrl    = ctrl_q;
    assign ex_pc4     = pc4_q;
    assign ex_rdata1  = rdata1_q;
    assign ex_rdata2  = rdata2_q;
    assign ex_imm     = imm_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Directed bench for id_ex_stage_reg (built with CNT_W=4 so saturation is
// reachable). Inputs change 1 ns after a rising edge; outputs are sampled at
// that same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [1:0]        id_ALUOp;
    logic [5:0]        id_funct;
    logic [6:0]        id_ctrl;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              ex_valid;
    logic [1:0]        ex_ALUOp;
    logic [5:0]        ex_funct;
    logic [6:0]        ex_ctrl;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [CNT_W-1:0]  bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ALUOp   (id_ALUOp),
        .id_funct   (id_funct),
        .id_ctrl    (id_ctrl),
        .id_pc4     (id_pc4),
        .id_rdata1  (id_rdata1),
        .id_rdata2  (id_rdata2),
        .id_imm     (id_imm),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .ex_valid   (ex_valid),
        .ex_ALUOp   (ex_ALUOp),
        .ex_funct   (ex_funct),
        .ex_ctrl    (ex_ctrl),
        .ex_pc4     (ex_pc4),
        .ex_rdata1  (ex_rdata1),
        .ex_rdata2  (ex_rdata2),
        .ex_imm     (ex_imm),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .bubble_cnt (bubble_cnt)
    );

    // Downstream ALUCtrl and JR_Ctrl decode, as seen by EX.
    function automatic logic [3:0] alu_ctrl(input logic [1:0] op, input logic [5:0] fn);
        case (op)
            2'b00:   return 4'b0010;
            2'b01:   return 4'b0110;
            default: begin
                case (fn)
                    6'b100000: return 4'b0010;
                    6'b100010: return 4'b0110;
                    6'b100100: return 4'b0000;
                    6'b100101: return 4'b0001;
                    6'b101010: return 4'b0111;
                    default:   return 4'b1111;
                endcase
            end
        endcase
    endfunction

    function automatic logic jr_ctrl(input logic [1:0] op, input logic [5:0] fn);
        return (op == 2'b10) && (fn[3:0] == 4'b1000);
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [6:0] ctl, input logic [31:0] pc4);
        id_valid  = v;
        id_ALUOp  = op;
        id_funct  = fn;
        id_ctrl   = ctl;
        id_pc4    = pc4;
        id_rdata1 = pc4 ^ 32'h1111_0000;
        id_rdata2 = pc4 ^ 32'h2222_0000;
        id_imm    = pc4 ^ 32'h3333_0000;
        id_rs     = pc4[6:2];
        id_rt     = pc4[7:3];
        id_rd     = pc4[8:4];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"},  ex_valid,   0);
        check({tag, ".aluop"},  ex_ALUOp,   0);
        check({tag, ".funct"},  ex_funct,   0);
        check({tag, ".ctrl"},   ex_ctrl,    0);
        check({tag, ".pc4"},    ex_pc4,     0);
        check({tag, ".rdata1"}, ex_rdata1,  0);
        check({tag, ".rdata2"}, ex_rdata2,  0);
        check({tag, ".imm"},    ex_imm,     0);
        check({tag, ".rs"},     ex_rs,      0);
        check({tag, ".rt"},     ex_rt,      0);
        check({tag, ".rd"},     ex_rd,      0);
        check({tag, ".cnt"},    bubble_cnt, 0);
    endtask

    initial begin
        // Reset with busy inputs so the zeros are meaningful.
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b1;
        drive(1'b1, 2'b10, 6'b100000, 7'b1000010, 32'h0000_0100);
        step();
        step();
        check_all_zero("reset");

        // R-type add load, 1-cycle latency.
        rst_n = 1'b1;
        flush = 1'b0;
        drive(1'b1, 2'b10, 6'b100000, 7'b1000010, 32'h0000_0104);
        step();
        check("add.valid",   ex_valid,  1);
        check("add.aluop",   ex_ALUOp,  2'b10);
        check("add.funct",   ex_funct,  6'b100000);
        check("add.ctrl",    ex_ctrl,   7'b1000010);
        check("add.aluctrl", alu_ctrl(ex_ALUOp, ex_funct), 4'b0010);
        check("add.pc4",     ex_pc4,    32'h0000_0104);
        check("add.rdata1",  ex_rdata1, 32'h1111_0104);
        check("add.rdata2",  ex_rdata2, 32'h2222_0104);
        check("add.imm",     ex_imm,    32'h3333_0104);
        check("add.rs",      ex_rs,     5'd1);
        check("add.rt",      ex_rt,     5'd0);
        check("add.rd",      ex_rd,     5'd16);
        check("add.cnt",     bubble_cnt, 0);

        // Sub, then a 3-cycle stall while ID presents an and.
        drive(1'b1, 2'b10, 6'b100010, 7'b1000010, 32'h0000_0108);
        step();
        check("sub.funct",   ex_funct, 6'b100010);
        check("sub.aluctrl", alu_ctrl(ex_ALUOp, ex_funct), 4'b0110);
        stall = 1'b1;
        drive(1'b1, 2'b10, 6'b100100, 7'b1000010, 32'h0000_010C);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall.funct", ex_funct, 6'b100010);
            check("stall.pc4",   ex_pc4,   32'h0000_0108);
            check("stall.valid", ex_valid, 1);
        end
        stall = 1'b0;
        step();
        check("and.funct",   ex_funct, 6'b100100);
        check("and.pc4",     ex_pc4,   32'h0000_010C);
        check("and.aluctrl", alu_ctrl(ex_ALUOp, ex_funct), 4'b0000);
        check("and.cnt",     bubble_cnt, 0);

        // Flush of a jr.
        flush = 1'b1;
        drive(1'b1, 2'b00, 6'b001000, 7'b1000000, 32'h0000_0110);
        step();
        check("jrf.valid", ex_valid, 0);
        check("jrf.funct", ex_funct, 0);
        check("jrf.ctrl",  ex_ctrl,  0);
        check("jrf.aluop", ex_ALUOp, 0);
        check("jrf.jr",    jr_ctrl(ex_ALUOp, ex_funct), 0);
        check("jrf.cnt",   bubble_cnt, 1);

        // Natural bubble from ID: control squashed, counter untouched.
        flush = 1'b0;
        drive(1'b0, 2'b10, 6'b001000, 7'b1111111, 32'h0000_0114);
        step();
        check("nat.valid", ex_valid, 0);
        check("nat.ctrl",  ex_ctrl,  0);
        check("nat.funct", ex_funct, 0);
        check("nat.aluop", ex_ALUOp, 0);
        check("nat.cnt",   bubble_cnt, 1);

        // Stall and flush together: flush wins.
        drive(1'b1, 2'b10, 6'b100101, 7'b1000010, 32'h0000_0118);
        step();
        check("or.valid", ex_valid, 1);
        check("or.funct", ex_funct, 6'b100101);
        stall = 1'b1;
        flush = 1'b1;
        step();
        check("sf.valid", ex_valid, 0);
        check("sf.ctrl",  ex_ctrl,  0);
        check("sf.cnt",   bubble_cnt, 2);
        stall = 1'b0;

        // Saturation: 20 consecutive flushes.
        exp_cnt = 2;
        for (int i = 0; i < 20; i++) begin
            step();
            if (exp_cnt < 15) exp_cnt++;
            check("sat.cnt", bubble_cnt, exp_cnt);
        end
        check("sat.final", bubble_cnt, 4'hF);

        // Load real instruction, stall it, then reset mid-stall.
        flush = 1'b0;
        drive(1'b1, 2'b10, 6'b101010, 7'b1000010, 32'h0000_011C);
        step();
        check("slt.valid", ex_valid, 1);
        check("slt.cnt",   bubble_cnt, 4'hF);
        stall = 1'b1;
        step();
        check("slt.hold", ex_funct, 6'b101010);
        rst_n = 1'b0;
        step();
        check_all_zero("rststall");
        rst_n = 1'b1;
        stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
